corelet_ctrl: RTL and testbench
===============================

CORELET_CTRL -- requirements
Module: corelet_ctrl

Interface
REQ-001 Parameters, one per line: ROW, default 8, PE rows / L0 depth per load; COL, default 8, PE columns; KIJ, default 9, kernel positions per run; LEN_W, default 8, width of len; AW, default 11, SRAM address width; W_BASE, default 11'd1024, weight region base in xmem.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 start  input  1  one-cycle run request; sampled only in IDLE.
REQ-005 len  input  LEN_W  activation vectors per kij; latched at start.
REQ-006 ofifo_valid  input  1  OFIFO holds at least one readable row.
REQ-007 inst  output  34  corelet instruction word: [1:0] mac inst_w (01 kernel load, 10 execute), [2] L0 wr, [3] L0 rd, [5] relu, [6] OFIFO rd, [33] SFP acc; all other bits 0.
REQ-008 xmem_rd  output  1  activation/weight SRAM read enable.
REQ-009 xmem_addr  output  AW  activation/weight SRAM address.
REQ-010 pmem_wr  output  1  psum SRAM write enable.
REQ-011 pmem_rd  output  1  psum SRAM read enable.
REQ-012 pmem_addr  output  AW  psum SRAM address.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on the cycle DONE is entered.

Function
REQ-015 All outputs registered; inst bits apply one cycle after the matching xmem_rd, covering the 1-cycle SRAM read latency.
REQ-016 FSM states: IDLE, W_LD, K_LD, X_LD, EXEC, DRAIN, OF_RD, ACC, SFP_WB, DONE.
REQ-017 IDLE -> W_LD on start with len!=0; start with len==0 -> DONE directly, no inst activity.
REQ-018 W_LD: ROW cycles; xmem_rd=1, xmem_addr=W_BASE+kij*ROW+cnt; inst[2]=1 one cycle later.
REQ-019 K_LD: ROW cycles; inst[3]=1, inst[1:0]=01.
REQ-020 X_LD: len cycles; xmem_rd=1, xmem_addr=cnt; inst[2]=1 one cycle later.
REQ-021 EXEC: len cycles; inst[3]=1, inst[1:0]=10.
REQ-022 DRAIN: ROW+COL cycles; inst all 0.
REQ-023 OF_RD: inst[6]=1 only when ofifo_valid=1; pmem_wr follows each read by one cycle at pmem_addr=kij*len+rd_cnt; exits after exactly len reads, stalling indefinitely while ofifo_valid=0.
REQ-024 After OF_RD: kij<KIJ-1 -> kij+1, go to W_LD; else kij=0, go to ACC.
REQ-025 ACC: for output o=0..len-1 and k=0..KIJ-1, pmem_rd=1 at pmem_addr=k*len+o; inst[33]=1 one cycle later; after k=KIJ-1 go to SFP_WB.
REQ-026 SFP_WB: one cycle, pmem_wr=1 at pmem_addr=KIJ*len+o; then o+1 returns to ACC, last o goes to DONE.
REQ-027 DONE: one cycle with done=1, then IDLE.
REQ-028 start while busy is ignored; len changes while busy are ignored.
REQ-029 Address arithmetic is modulo 2^AW; wrap-around is silent.
REQ-030 Counters cnt, kij, o and rd_cnt clear on every state entry that restarts them.

Reset
REQ-031 reset forces IDLE from any state, including mid-run, on the same edge.
REQ-032 reset values: inst=0, xmem_rd=0, pmem_wr=0, pmem_rd=0, xmem_addr=0, pmem_addr=0, busy=0, done=0.
REQ-033 reset clears every counter and the latched len.
REQ-034 The first start is accepted on the cycle after reset deasserts.

Configuration
REQ-035 Macro CTRL_RELU_EN defined: inst[5]=1 on every cycle inst[33]=1 in ACC.
REQ-036 CTRL_RELU_EN undefined: inst[5] is constant 0.

Verification
REQ-037 len=4, KIJ=9, ofifo_valid=1 -> W_LD addresses 1024..1031 for kij0; 9 OF_RD bursts write pmem 0..35; SFP_WB writes 36..39; one done pulse.
REQ-038 start with len=0 -> done exactly 2 cycles after start; inst never nonzero.
REQ-039 ofifo_valid low for 5 cycles mid-OF_RD at len=4 -> exactly 4 inst[6] pulses; pmem addresses contiguous, no duplicates.
REQ-040 reset asserted during EXEC of kij=3 -> next cycle all outputs 0 and busy=0; a new start replays from kij=0.
REQ-041 start re-pulsed during EXEC -> ignored; run completes with a single done pulse.
REQ-042 ACC with CTRL_RELU_EN defined vs undefined -> inst[5] mirrors inst[33] vs stays 0.

Source files
------------

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: sequencer for one convolution run on the corelet.
//
// For each of KIJ kernel positions it loads ROW weight rows from xmem into
// L0 (W_LD), pushes them into the PE array (K_LD), streams len activation
// vectors into L0 (X_LD) and through the array (EXEC), waits for the array
// to empty (DRAIN), then moves len output rows from the OFIFO into psum
// memory (OF_RD). After the last kernel position, every output o is rebuilt
// by reading its KIJ partial sums through the SFP accumulator (ACC). The
// result is written back above the partial-sum region (SFP_WB).
//
// Optional feature macro: CTRL_RELU_EN. When defined, inst[5] (relu)
// follows inst[33] during accumulation. When undefined, inst[5] is tied 0.
//
// Ports
//   clk, reset     rising-edge clock, synchronous active-high reset
//   start          one-cycle run request, only looked at in IDLE
//   len            activation vectors per kernel position, latched at start
//   ofifo_valid    OFIFO has a readable row; each cycle it is high in OF_RD
//                  counts as one read (no ready: the OFIFO pop is inst[6])
//   inst[33:0]     corelet instruction word ([1:0] mac, [2] L0 wr, [3] L0 rd,
//                  [5] relu, [6] OFIFO rd, [33] SFP acc; others 0)
//   xmem_rd/addr   activation/weight SRAM read port
//   pmem_wr/rd/addr psum SRAM port (one address, read or write)
//   busy, done     status; done pulses once per run
//   dbg_state      current FSM state, for observation only
//
// Timing: stage 1 registers decode the current state (xmem_rd, mac/L0 rd,
// OFIFO rd, busy, done). Stage 2 adds the SRAM read latency (L0 wr) and
// issues all pmem traffic. Stage 3 carries the SFP accumulate. Keeping all
// pmem traffic on one stage means the last OF_RD write and the first ACC read
// never share the single pmem address.
module corelet_ctrl #(
  parameter int ROW = 8,
  parameter int COL = 8,
  parameter int KIJ = 9,
  parameter int LEN_W = 8,
  parameter int AW = 11,
  parameter logic [AW-1:0] W_BASE = 11'd1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             ofifo_valid,
  output logic [33:0]      inst,
  output logic             xmem_rd,
  output logic [AW-1:0]    xmem_addr,
  output logic             pmem_wr,
  output logic             pmem_rd,
  output logic [AW-1:0]    pmem_addr,
  output logic             busy,
  output logic             done,
  output logic [3:0]       dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_W_LD   = 4'd1,
    S_K_LD   = 4'd2,
    S_X_LD   = 4'd3,
    S_EXEC   = 4'd4,
    S_DRAIN  = 4'd5,
    S_OF_RD  = 4'd6,
    S_ACC    = 4'd7,
    S_SFP_WB = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  localparam int CW = 16;
  localparam int KW = (KIJ > 1) ? $clog2(KIJ) : 1;
  localparam logic [CW-1:0] ROW_M1   = CW'(ROW - 1);
  localparam logic [CW-1:0] DRAIN_M1 = CW'(ROW + COL - 1);
  localparam logic [CW-1:0] KIJ_M1_C = CW'(KIJ - 1);
  localparam logic [KW-1:0] KIJ_M1_K = KW'(KIJ - 1);
  localparam logic [AW-1:0] ROW_A    = AW'(ROW);
  localparam logic [AW-1:0] KIJ_A    = AW'(KIJ);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [KW-1:0]    kij, kij_n;
  logic [LEN_W-1:0] o, o_n;
  logic [LEN_W-1:0] rd_cnt, rd_cnt_n;
  logic [LEN_W-1:0] len_q, len_q_n;

  logic [CW-1:0]    len_m1_c;
  logic [LEN_W-1:0] len_m1;
  logic [AW-1:0]    cnt_a, kij_a, len_a, o_a, rd_a;
  logic [AW-1:0]    w_addr, of_addr, acc_addr, sfp_addr;

  // Stage registers behind inst and the pmem port.
  logic [1:0]       mac;
  logic             l0_wr, l0_rd, of_rd, acc, relu;
  logic [AW-1:0]    of_addr_q, p_addr_q;
  logic             p_rd_q, p_wr_q;

  assign len_m1_c = CW'(len_q) - CW'(1);
  assign len_m1   = len_q - LEN_W'(1);

  // All address math is done at AW bits so it wraps silently.
  assign cnt_a    = AW'(cnt);
  assign kij_a    = AW'(kij);
  assign len_a    = AW'(len_q);
  assign o_a      = AW'(o);
  assign rd_a     = AW'(rd_cnt);
  assign w_addr   = W_BASE + kij_a * ROW_A + cnt_a;
  assign of_addr  = kij_a * len_a + rd_a;
  assign acc_addr = cnt_a * len_a + o_a;
  assign sfp_addr = KIJ_A * len_a + o_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      kij    <= '0;
      o      <= '0;
      rd_cnt <= '0;
      len_q  <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      kij    <= kij_n;
      o      <= o_n;
      rd_cnt <= rd_cnt_n;
      len_q  <= len_q_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    kij_n    = kij;
    o_n      = o;
    rd_cnt_n = rd_cnt;
    len_q_n  = len_q;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          len_q_n  = len;
          cnt_n    = '0;
          kij_n    = '0;
          o_n      = '0;
          rd_cnt_n = '0;
          state_n  = (len != '0) ? S_W_LD : S_DONE;
        end
      end
      S_W_LD: begin
        if (cnt == ROW_M1) begin
          cnt_n   = '0;
          state_n = S_K_LD;
        end else cnt_n = cnt + CW'(1);
      end
      S_K_LD: begin
        if (cnt == ROW_M1) begin
          cnt_n   = '0;
          state_n = S_X_LD;
        end else cnt_n = cnt + CW'(1);
      end
      S_X_LD: begin
        if (cnt == len_m1_c) begin
          cnt_n   = '0;
          state_n = S_EXEC;
        end else cnt_n = cnt + CW'(1);
      end
      S_EXEC: begin
        if (cnt == len_m1_c) begin
          cnt_n   = '0;
          state_n = S_DRAIN;
        end else cnt_n = cnt + CW'(1);
      end
      S_DRAIN: begin
        if (cnt == DRAIN_M1) begin
          cnt_n    = '0;
          rd_cnt_n = '0;
          state_n  = S_OF_RD;
        end else cnt_n = cnt + CW'(1);
      end
      S_OF_RD: begin
        // Only cycles with a readable row count; otherwise wait here.
        if (ofifo_valid) begin
          if (rd_cnt == len_m1) begin
            rd_cnt_n = '0;
            cnt_n    = '0;
            if (kij == KIJ_M1_K) begin
              kij_n   = '0;
              o_n     = '0;
              state_n = S_ACC;
            end else begin
              kij_n   = kij + KW'(1);
              state_n = S_W_LD;
            end
          end else rd_cnt_n = rd_cnt + LEN_W'(1);
        end
      end
      S_ACC: begin
        if (cnt == KIJ_M1_C) begin
          cnt_n   = '0;
          state_n = S_SFP_WB;
        end else cnt_n = cnt + CW'(1);
      end
      S_SFP_WB: begin
        cnt_n = '0;
        if (o == len_m1) begin
          o_n     = '0;
          state_n = S_DONE;
        end else begin
          o_n     = o + LEN_W'(1);
          state_n = S_ACC;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xmem_rd   <= 1'b0;
      xmem_addr <= '0;
      mac       <= 2'b00;
      l0_rd     <= 1'b0;
      of_rd     <= 1'b0;
      of_addr_q <= '0;
      p_rd_q    <= 1'b0;
      p_wr_q    <= 1'b0;
      p_addr_q  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      l0_wr     <= 1'b0;
      pmem_wr   <= 1'b0;
      pmem_rd   <= 1'b0;
      pmem_addr <= '0;
      acc       <= 1'b0;
    end else begin
      // Stage 1: decode of the current state.
      xmem_rd <= (state == S_W_LD) || (state == S_X_LD);
      if (state == S_W_LD)      xmem_addr <= w_addr;
      else if (state == S_X_LD) xmem_addr <= cnt_a;
      mac       <= (state == S_K_LD) ? 2'b01 : (state == S_EXEC) ? 2'b10 : 2'b00;
      l0_rd     <= (state == S_K_LD) || (state == S_EXEC);
      of_rd     <= (state == S_OF_RD) && ofifo_valid;
      of_addr_q <= of_addr;
      p_rd_q    <= (state == S_ACC);
      p_wr_q    <= (state == S_SFP_WB);
      p_addr_q  <= (state == S_ACC) ? acc_addr : sfp_addr;
      busy      <= (state != S_IDLE);
      done      <= (state == S_DONE);
      // Stage 2: L0 write lands with the SRAM data; pmem traffic.
      l0_wr   <= xmem_rd;
      pmem_wr <= of_rd || p_wr_q;
      pmem_rd <= p_rd_q;
      if (of_rd)                 pmem_addr <= of_addr_q;
      else if (p_rd_q || p_wr_q) pmem_addr <= p_addr_q;
      // Stage 3: accumulate once the psum read data is available.
      acc <= pmem_rd;
    end
  end

`ifdef CTRL_RELU_EN
  always_ff @(posedge clk) begin
    if (reset) relu <= 1'b0;
    else       relu <= pmem_rd;
  end
`else
  assign relu = 1'b0;
`endif

  assign inst = {acc, 26'b0, of_rd, relu, 1'b0, l0_rd, l0_wr, mac};
  assign dbg_state = state;

endmodule

// File: tb/tb_corelet_ctrl.sv
`timescale 1ns/1ps
module tb_corelet_ctrl;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int KIJ = 9;
  localparam int LEN_W = 8;
  localparam int AW = 11;
  localparam int W_BASE = 1024;
  localparam int AMOD = 1 << AW;
  localparam int BUDGET = 30000;
  localparam logic [63:0] INST_MASK = 64'h0000_0002_0000_006F;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             ofifo_valid;
  logic [33:0]      inst;
  logic             xmem_rd;
  logic [AW-1:0]    xmem_addr;
  logic             pmem_wr;
  logic             pmem_rd;
  logic [AW-1:0]    pmem_addr;
  logic             busy;
  logic             done;
  logic [3:0]       dbg_state;

  corelet_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .ofifo_valid(ofifo_valid),
    .inst(inst), .xmem_rd(xmem_rd), .xmem_addr(xmem_addr), .pmem_wr(pmem_wr),
    .pmem_rd(pmem_rd), .pmem_addr(pmem_addr), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // Clock / cycle index
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  // Scoreboard: expected address streams in issue order.
  logic [AW-1:0] exp_x_q[$];
  logic [AW-1:0] exp_pw_q[$];
  logic [AW-1:0] exp_pr_q[$];

  // Observed event counts for the current run.
  int cnt_kload, cnt_exec, cnt_l0rd, cnt_l0wr, cnt_of, cnt_acc, cnt_nz, done_cnt, done_cyc;
  logic prev_x, prev_pr, prev_of;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: what a run of length l must issue, in order.
  task automatic build_model(input int l);
    exp_x_q.delete();
    exp_pw_q.delete();
    exp_pr_q.delete();
    if (l == 0) return;
    for (int k = 0; k < KIJ; k++) begin
      for (int c = 0; c < ROW; c++) exp_x_q.push_back(AW'((W_BASE + k * ROW + c) % AMOD));
      for (int c = 0; c < l; c++)   exp_x_q.push_back(AW'(c % AMOD));
      for (int r = 0; r < l; r++)   exp_pw_q.push_back(AW'((k * l + r) % AMOD));
    end
    for (int oo = 0; oo < l; oo++) begin
      for (int k = 0; k < KIJ; k++) exp_pr_q.push_back(AW'((k * l + oo) % AMOD));
      exp_pw_q.push_back(AW'((KIJ * l + oo) % AMOD));
    end
  endtask

  // Per-cycle observation, called once per falling edge.
  task automatic monitor();
    logic [AW-1:0] e;
    if (reset) begin
      prev_x = 1'b0; prev_pr = 1'b0; prev_of = 1'b0;
      return;
    end
    chk("l0_wr_align", 64'(inst[2]), 64'(prev_x));
    chk("acc_align", 64'(inst[33]), 64'(prev_pr));
`ifdef CTRL_RELU_EN
    chk("relu", 64'(inst[5]), 64'(prev_pr));
`else
    chk("relu", 64'(inst[5]), 64'(0));
`endif
    chk("inst_bits", 64'(inst) & ~INST_MASK, 64'(0));
    chk("mac_code", 64'(inst[1:0] == 2'b11), 64'(0));
    if (prev_of) chk("of_writeback", 64'(pmem_wr), 64'(1));
    if (xmem_rd) begin
      if (exp_x_q.size() == 0) chk("xmem_extra", 64'(1), 64'(0));
      else begin e = exp_x_q.pop_front(); chk("xmem_addr", 64'(xmem_addr), 64'(e)); end
    end
    if (pmem_wr) begin
      if (exp_pw_q.size() == 0) chk("pmem_wr_extra", 64'(1), 64'(0));
      else begin e = exp_pw_q.pop_front(); chk("pmem_wr_addr", 64'(pmem_addr), 64'(e)); end
    end
    if (pmem_rd) begin
      if (exp_pr_q.size() == 0) chk("pmem_rd_extra", 64'(1), 64'(0));
      else begin e = exp_pr_q.pop_front(); chk("pmem_rd_addr", 64'(pmem_addr), 64'(e)); end
    end
    if (inst[1:0] == 2'b01) cnt_kload++;
    if (inst[1:0] == 2'b10) cnt_exec++;
    if (inst[3])  cnt_l0rd++;
    if (inst[2])  cnt_l0wr++;
    if (inst[6])  cnt_of++;
    if (inst[33]) cnt_acc++;
    if (inst != '0) cnt_nz++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    prev_x = xmem_rd; prev_pr = pmem_rd; prev_of = inst[6];
  endtask

  // Driver: advance to the next falling edge, observe, then drive.
  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_inst"}, 64'(inst), 64'(0));
    chk({tag, "_xmem_rd"}, 64'(xmem_rd), 64'(0));
    chk({tag, "_xmem_addr"}, 64'(xmem_addr), 64'(0));
    chk({tag, "_pmem_wr"}, 64'(pmem_wr), 64'(0));
    chk({tag, "_pmem_rd"}, 64'(pmem_rd), 64'(0));
    chk({tag, "_pmem_addr"}, 64'(pmem_addr), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
  endtask

  // mode: 0 ofifo always valid, 1 random ofifo, 2 five-cycle ofifo hole
  // mid OF_RD, 3 reset during EXEC of kernel position 3 (aborts the run).
  task automatic run_vec(input int l, input int mode, input bit spur, input int exp_lat);
    int start_idx;
    int hole;
    bit aborted, spur_done, hole_done;
    hole = 0; aborted = 0; spur_done = 0; hole_done = 0;
    build_model(l);
    cnt_kload = 0; cnt_exec = 0; cnt_l0rd = 0; cnt_l0wr = 0; cnt_of = 0;
    cnt_acc = 0; cnt_nz = 0; done_cnt = 0; done_cyc = 0;
    tick();
    start = 1'b1; len = LEN_W'(l); ofifo_valid = 1'b1;
    start_idx = cyc + 1;
    tick();
    start = 1'b0; len = LEN_W'($urandom_range(0, 255));
    tick();
    chk("busy_in_run", 64'(busy), 64'(1));
    for (int w = 0; w < BUDGET && done_cnt == 0; w++) begin
      tick();
      start = 1'b0;
      len = LEN_W'($urandom_range(0, 255));
      if (mode == 1) ofifo_valid = 1'($urandom_range(0, 1));
      if (mode == 2) begin
        if (!hole_done && cnt_of >= 2) begin hole = 5; hole_done = 1; end
        if (hole > 0) begin ofifo_valid = 1'b0; hole--; end
        else ofifo_valid = 1'b1;
      end
      if (mode == 3 && cnt_exec >= 3 * l + 2) begin
        reset = 1'b1;
        tick();
        check_zero("abort");
        reset = 1'b0;
        aborted = 1;
        break;
      end
      if (spur && !spur_done && cnt_exec >= 1) begin start = 1'b1; spur_done = 1; end
    end
    if (aborted) return;
    start = 1'b0; ofifo_valid = 1'b1;
    for (int w = 0; w < 4; w++) tick();
    chk("done_pulses", 64'(done_cnt), 64'(1));
    if (exp_lat != 0 && done_cnt != 0) chk("done_latency", 64'(done_cyc - start_idx + 1), 64'(exp_lat));
    chk("xmem_left", 64'(exp_x_q.size()), 64'(0));
    chk("pmem_wr_left", 64'(exp_pw_q.size()), 64'(0));
    chk("pmem_rd_left", 64'(exp_pr_q.size()), 64'(0));
    chk("ofifo_reads", 64'(cnt_of), 64'(l == 0 ? 0 : KIJ * l));
    chk("kernel_loads", 64'(cnt_kload), 64'(l == 0 ? 0 : KIJ * ROW));
    chk("executes", 64'(cnt_exec), 64'(KIJ * l));
    chk("l0_reads", 64'(cnt_l0rd), 64'(l == 0 ? 0 : KIJ * (ROW + l)));
    chk("l0_writes", 64'(cnt_l0wr), 64'(l == 0 ? 0 : KIJ * (ROW + l)));
    chk("acc_pulses", 64'(cnt_acc), 64'(KIJ * l));
    if (l == 0) chk("inst_activity", 64'(cnt_nz), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
  endtask

  typedef struct {
    int len;
    int mode;
    bit spur;
    int exp_lat;  // start cycle to done cycle; 0 = not checked
  } vec_t;

  vec_t tbl[8];

  initial begin
    // start-to-done: 2 + KIJ*(3*ROW+COL+3*len) + len*(KIJ+1) = 290 + 37*len
    tbl[0] = '{len: 4,   mode: 0, spur: 1'b0, exp_lat: 438};
    tbl[1] = '{len: 0,   mode: 0, spur: 1'b0, exp_lat: 2};
    tbl[2] = '{len: 1,   mode: 0, spur: 1'b0, exp_lat: 327};
    tbl[3] = '{len: 4,   mode: 2, spur: 1'b0, exp_lat: 443};
    tbl[4] = '{len: 4,   mode: 3, spur: 1'b0, exp_lat: 0};
    tbl[5] = '{len: 4,   mode: 0, spur: 1'b1, exp_lat: 438};
    tbl[6] = '{len: 255, mode: 0, spur: 1'b0, exp_lat: 9725};
    tbl[7] = '{len: 8,   mode: 1, spur: 1'b0, exp_lat: 0};

    reset = 1'b1; start = 1'b0; len = '0; ofifo_valid = 1'b1;
    prev_x = 1'b0; prev_pr = 1'b0; prev_of = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    chk("reset_state", 64'(dbg_state), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(tbl[i].len, tbl[i].mode, tbl[i].spur, tbl[i].exp_lat);
    for (int r = 0; r < 4; r++)
      run_vec($urandom_range(1, 16), 1, 1'($urandom_range(0, 1)), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
